decoder_bs_fetch: RTL and testbench

- Bitstream fetch stage, directly downstream of the decoder register file.
- On a start pulse it captures buffer_req_base (x0) and buffer_req_end (x1) from the regfile outputs.
- It then issues sequential 64-bit reads to data memory over [base, end) and buffers the returned words in a small FIFO.
- It streams the words to the H.264 syntax parser over a valid/ready interface and reports busy/done to the accelerator controller.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_bs_fifo.sv | 69 ++++++
 rtl/decoder_bs_fetch.sv | 152 +++++++++++++++
 tb/tb_decoder_bs_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder bitstream fetch path.
package decoder_pkg;

  typedef enum logic [1:0] {
    BS_IDLE  = 2'd0,
    BS_FETCH = 2'd1,
    BS_DRAIN = 2'd2,
    BS_FLUSH = 2'd3
  } bs_fetch_state_e;

  localparam int unsigned BS_WORD_BYTES = 8;
  // Low address bits that are cleared when base/end are captured.
  localparam int unsigned BS_ADDR_ALIGN_MASK = BS_WORD_BYTES - 1;

endpackage

// File: rtl/decoder_bs_fifo.sv
// Synchronous FIFO with clear; head word is visible combinationally while not empty.
module decoder_bs_fifo
  import decoder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != CW'(DEPTH)) && !clear_i;
    do_pop   = pop_i && (count_q != '0) && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/decoder_bs_fetch.sv
// Bitstream fetch: reads [base, end) from data memory in 64-bit words and streams them to the parser.
// Define DECODER_BS_FETCH_BYTESWAP_EN to byte-reverse each word into big-endian H.264 order.
`ifndef CORE_DATAWIDTH
`define CORE_DATAWIDTH 32
`endif
`ifndef CORE_ADDRWIDTH
`define CORE_ADDRWIDTH 32
`endif

module decoder_bs_fetch
  import decoder_pkg::*;
#(
  parameter int DMEM_DATA_WIDTH = 64,
  parameter int ACC_DATA_WIDTH  = `CORE_DATAWIDTH,
  parameter int ACC_ADDR_WIDTH  = `CORE_ADDRWIDTH,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       flush_i,
  input  logic [ACC_DATA_WIDTH-1:0]  rf_buffer_req_base_i,
  input  logic [ACC_DATA_WIDTH-1:0]  rf_buffer_req_end_i,
  output logic                       mem_req_o,
  output logic [ACC_ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_rdata_i,
  output logic                       bs_valid_o,
  output logic [DMEM_DATA_WIDTH-1:0] bs_data_o,
  input  logic                       bs_ready_i,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int AW = ACC_ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bs_fetch_state_e state_q, state_d;
  logic [AW-1:0] next_addr_q, next_addr_d, end_addr_q, end_addr_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          done_q, done_d;

  logic [AW-1:0] base_aligned, end_aligned;
  logic [AW:0]   addr_plus;
  logic          range_empty, last_grant, room;
  logic          grant_take, rvalid_take, flush_take, active;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [DMEM_DATA_WIDTH-1:0] push_word;

  assign base_aligned = rf_buffer_req_base_i[AW-1:0] & ~AW'(BS_ADDR_ALIGN_MASK);
  assign end_aligned  = rf_buffer_req_end_i[AW-1:0] & ~AW'(BS_ADDR_ALIGN_MASK);
  assign range_empty  = (end_aligned <= base_aligned);
  assign addr_plus    = {1'b0, next_addr_q} + (AW+1)'(BS_WORD_BYTES);
  assign last_grant   = (addr_plus >= {1'b0, end_addr_q});
  // Counting in-flight reads against free FIFO slots means returned data always has a home.
  assign room         = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BS_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BS_IDLE:  if (start_i && !flush_i && !range_empty) state_d = BS_FETCH;
      BS_FETCH: begin
        if (flush_i)                      state_d = BS_FLUSH;
        else if (grant_take && last_grant) state_d = BS_DRAIN;
      end
      BS_DRAIN: begin
        if (flush_i)                                    state_d = BS_FLUSH;
        else if ((outstanding_q == '0) && fifo_empty) state_d = BS_IDLE;
      end
      BS_FLUSH: if (outstanding_q == '0) state_d = BS_IDLE;
      default:  state_d = BS_IDLE;
    endcase
  end

  always_comb begin
    active        = (state_q == BS_FETCH) || (state_q == BS_DRAIN);
    mem_req_o     = (state_q == BS_FETCH) && room;
    mem_addr_o    = next_addr_q;
    busy_o        = (state_q != BS_IDLE);
    done_o        = done_q;
    grant_take    = mem_req_o && mem_gnt_i;
    rvalid_take   = mem_rvalid_i && (outstanding_q != '0);
    flush_take    = flush_i && active;
    fifo_push     = rvalid_take && active && !flush_take && !fifo_full;
    fifo_pop      = bs_valid_o && bs_ready_i;
    next_addr_d   = next_addr_q;
    end_addr_d    = end_addr_q;
    outstanding_d = outstanding_q;
    done_d        = 1'b0;

    if ((state_q == BS_IDLE) && start_i && !flush_i) begin
      next_addr_d = base_aligned;
      end_addr_d  = end_aligned;
      done_d      = range_empty;
    end
    if (grant_take) next_addr_d = addr_plus[AW-1:0];
    case ({grant_take, rvalid_take})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if ((state_q == BS_DRAIN) && !flush_i && (outstanding_q == '0) && fifo_empty)
      done_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_addr_q   <= '0;
      end_addr_q    <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else begin
      next_addr_q   <= next_addr_d;
      end_addr_q    <= end_addr_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
    end
  end

`ifdef DECODER_BS_FETCH_BYTESWAP_EN
  for (genvar gi = 0; gi < DMEM_DATA_WIDTH / 8; gi++) begin : g_swap
    assign push_word[8*gi +: 8] = mem_rdata_i[DMEM_DATA_WIDTH-8-8*gi +: 8];
  end
`else
  assign push_word = mem_rdata_i;
`endif

  decoder_bs_fifo #(
    .WIDTH (DMEM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_take),
    .push_i      (fifo_push),
    .push_data_i (push_word),
    .pop_i       (fifo_pop),
    .head_o      (bs_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bs_valid_o = !fifo_empty;

endmodule

// File: tb/tb_decoder_bs_fetch.sv
// Directed bench for decoder_bs_fetch: memory responder model plus address/data scoreboards.
module tb_decoder_bs_fetch;
  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i, bs_ready_i;
  logic [31:0] base_r, end_r;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_rdata_i = '0, bs_data_o;
  logic        bs_valid_o, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  decoder_bs_fetch #(
    .DMEM_DATA_WIDTH (64),
    .ACC_DATA_WIDTH  (32),
    .ACC_ADDR_WIDTH  (32),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .start_i              (start_i),
    .flush_i              (flush_i),
    .rf_buffer_req_base_i (base_r),
    .rf_buffer_req_end_i  (end_r),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .mem_gnt_i            (mem_gnt_i),
    .mem_rvalid_i         (mem_rvalid_i),
    .mem_rdata_i          (mem_rdata_i),
    .bs_valid_o           (bs_valid_o),
    .bs_data_o            (bs_data_o),
    .bs_ready_i           (bs_ready_i),
    .busy_o               (busy_o),
    .done_o               (done_o)
  );

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0;
  bit gnt_en = 1'b1;
  int grant_cnt = 0, word_cnt = 0, done_cnt = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  int          pend_due[$];
  logic [31:0] pend_addr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 64'h0011223344556677;
    return {32'hC0DE_0000 ^ a, ~a};
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] w);
    logic [63:0] r;
`ifdef DECODER_BS_FETCH_BYTESWAP_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  always @(posedge clk_i) cyc++;

  // Memory responder: grants the current request, returns data two cycles after the grant.
  always @(negedge clk_i) begin
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
    if (mem_req_o && gnt_en) begin
      mem_gnt_i = 1'b1;
      grant_cnt++;
      if (exp_addr_q.size() > 0) check("req_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
      else                       check("req_extra", 64'(mem_addr_o), 64'hx);
      $display("grant addr=%h", mem_addr_o);
      pend_due.push_back(cyc + 2);
      pend_addr.push_back(mem_addr_o);
    end else begin
      mem_gnt_i = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i && bs_valid_o && bs_ready_i) begin
      word_cnt++;
      if (exp_data_q.size() > 0) check("bs_data", bs_data_o, exp_data_q.pop_front());
      else                       check("bs_extra", bs_data_o, 64'hx);
      $display("bs word %0d data=%h", word_cnt, bs_data_o);
    end
    if (done_o) done_cnt++;
  end

  task automatic push_range(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] a  = b & ~32'h7;
    logic [31:0] ea = e & ~32'h7;
    while (a < ea) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(exp_word(mem_word(a)));
      a += 32'd8;
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] e);
    @(posedge clk_i); #1;
    base_r = b; end_r = e; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
    end
    check(tag, 64'(got), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, w0, d0;
    bit seen;
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; bs_ready_i = 1'b0;
    base_r = '0; end_r = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_valid", 64'(bs_valid_o), 64'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Single-word fetch
    bs_ready_i = 1'b1;
    g0 = grant_cnt; w0 = word_cnt;
    push_range(32'h100, 32'h108);
    pulse_start(32'h100, 32'h108);
    wait_done("single_done", 40);
    check("single_grants", 64'(grant_cnt - g0), 64'd1);
    check("single_words_before_done", 64'(word_cnt - w0), 64'd1);
    @(negedge clk_i);
    check("single_done_pulse", 64'(done_o), 64'd0);

    // Empty range
    g0 = grant_cnt; d0 = done_cnt;
    pulse_start(32'h200, 32'h200);
    @(negedge clk_i);
    check("empty_done", 64'(done_o), 64'd1);
    check("empty_req", 64'(mem_req_o), 64'd0);
    check("empty_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    check("empty_done_pulse", 64'(done_o), 64'd0);
    check("empty_done_count", 64'(done_cnt - d0), 64'd1);
    check("empty_grants", 64'(grant_cnt - g0), 64'd0);

    // Backpressure: FIFO plus in-flight reads cap at four
    @(posedge clk_i); #1 bs_ready_i = 1'b0;
    g0 = grant_cnt; w0 = word_cnt;
    push_range(32'h0, 32'h40);
    pulse_start(32'h0, 32'h40);
    repeat (20) @(negedge clk_i);
    check("bp_grants", 64'(grant_cnt - g0), 64'd4);
    check("bp_req_low", 64'(mem_req_o), 64'd0);
    check("bp_valid", 64'(bs_valid_o), 64'd1);
    @(posedge clk_i); #1 bs_ready_i = 1'b1;
    wait_done("bp_done", 200);
    check("bp_words", 64'(word_cnt - w0), 64'd8);
    check("bp_grants_total", 64'(grant_cnt - g0), 64'd8);
    check("bp_queue_empty", 64'(exp_data_q.size()), 64'd0);

    // Unaligned range
    g0 = grant_cnt;
    push_range(32'h103, 32'h111);
    pulse_start(32'h103, 32'h111);
    wait_done("unal_done", 60);
    check("unal_grants", 64'(grant_cnt - g0), 64'd2);
    check("unal_addr_queue", 64'(exp_addr_q.size()), 64'd0);

    // Flush with two reads in flight and one word buffered
    @(posedge clk_i); #1 bs_ready_i = 1'b0;
    push_range(32'h0, 32'h40);
    pulse_start(32'h0, 32'h40);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk_i); #1;
      if (bs_valid_o) seen = 1'b1;
    end
    check("flush_first_word", 64'(seen), 64'd1);
    flush_i = 1'b1; gnt_en = 1'b0;
    d0 = done_cnt;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    check("flush_fifo_clear", 64'(bs_valid_o), 64'd0);
    check("flush_req_low", 64'(mem_req_o), 64'd0);
    check("flush_busy", 64'(busy_o), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (!busy_o) seen = 1'b1;
    end
    check("flush_idle", 64'(seen), 64'd1);
    check("flush_reads_returned", 64'(pend_due.size()), 64'd0);
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);
    check("flush_valid_after", 64'(bs_valid_o), 64'd0);
    @(posedge clk_i); #1 gnt_en = 1'b1; bs_ready_i = 1'b1;
    w0 = word_cnt;
    push_range(32'h0, 32'h8);
    pulse_start(32'h0, 32'h8);
    wait_done("post_flush_done", 40);
    check("post_flush_words", 64'(word_cnt - w0), 64'd1);

    // Reset mid-fetch, then stale responses arrive in IDLE
    @(posedge clk_i); #1 bs_ready_i = 1'b0;
    push_range(32'h0, 32'h40);
    pulse_start(32'h0, 32'h40);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1; gnt_en = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_req", 64'(mem_req_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (bs_valid_o) seen = 1'b1;
    end
    check("stale_no_push", 64'(seen), 64'd0);
    check("stale_delivered", 64'(pend_due.size()), 64'd0);
    @(posedge clk_i); #1 gnt_en = 1'b1; bs_ready_i = 1'b1;
    w0 = word_cnt;
    push_range(32'h0, 32'h8);
    pulse_start(32'h0, 32'h8);
    wait_done("post_rst_done", 40);
    check("post_rst_words", 64'(word_cnt - w0), 64'd1);

    repeat (2) @(negedge clk_i);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
